gcd_driver: RTL and testbench



---
 rtl/gcd_driver.sv | 175 +++++++++++++++++
 tb/tb_gcd_driver.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_driver.sv
// gcd_driver: host-side initiator for the repeated-subtraction GCD engine.
// Takes operand pairs on a valid/ready port and loads them into the engine serially:
// start + A, then B. It waits for done and returns the result on a valid/ready port.
// Pairs with a zero operand are answered directly, because the engine would never finish on them.
// A job that runs past TIMEOUT wait cycles is abandoned and reported as a timeout.
// The engine is cleared after every job.

module gcd_driver #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic             clock,
    input  logic             reset,
    // Operand side
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    // Engine side
    output logic             gcd_start,
    output logic [WIDTH-1:0] gcd_data,
    output logic             gcd_rst,
    input  logic             gcd_done,
    input  logic [WIDTH-1:0] gcd_result,
    // Result side
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_timeout,
    output logic             busy
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoadA,
        StLoadB,
        StWait,
        StResp,
        StClear
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              timeout_q, timeout_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    // Output registers, loaded from the decode of the next state
    logic              op_ready_q;
    logic              gcd_start_q;
    logic [WIDTH-1:0]  gcd_data_q, gcd_data_d;
    logic              clear_q;
    logic              res_valid_q;
    logic [WIDTH-1:0]  res_data_q;
    logic              res_timeout_q;
    logic              busy_q;

    // Next-state and datapath logic for the job sequence
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        result_d  = result_q;
        timeout_d = timeout_q;
        cnt_d     = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (op_valid) begin
                    a_d = op_a;
                    b_d = op_b;
                    if (op_a == '0 || op_b == '0) begin
                        // Zero operand: the answer is the other operand, and the engine is not used.
                        result_d  = op_a | op_b;
                        timeout_d = 1'b0;
                        state_d   = StResp;
                    end else begin
                        state_d = StLoadA;
                    end
                end
            end
            StLoadA: begin
                state_d = StLoadB;
            end
            StLoadB: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                cnt_d = cnt_q + CntW'(1);
                // done is checked first, so it wins when it coincides with the last wait cycle
                if (gcd_done) begin
                    result_d  = gcd_result;
                    timeout_d = 1'b0;
                    state_d   = StResp;
                end else if (cnt_q == CntLast) begin
                    result_d  = '0;
                    timeout_d = 1'b1;
                    state_d   = StResp;
                end
            end
            StResp: begin
                if (res_ready) begin
                    state_d = StClear;
                end
            end
            StClear: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Engine data bus: A while loading A, B from then on until the job ends
    always_comb begin
        gcd_data_d = '0;
        unique case (state_d)
            StLoadA:         gcd_data_d = a_d;
            StLoadB, StWait: gcd_data_d = b_d;
            default:         gcd_data_d = '0;
        endcase
    end

    // State, operand/result registers and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= StIdle;
            a_q           <= '0;
            b_q           <= '0;
            result_q      <= '0;
            timeout_q     <= 1'b0;
            cnt_q         <= '0;
            op_ready_q    <= 1'b1;
            gcd_start_q   <= 1'b0;
            gcd_data_q    <= '0;
            clear_q       <= 1'b0;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
            res_timeout_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            a_q           <= a_d;
            b_q           <= b_d;
            result_q      <= result_d;
            timeout_q     <= timeout_d;
            cnt_q         <= cnt_d;
            op_ready_q    <= (state_d == StIdle);
            gcd_start_q   <= (state_d == StLoadA);
            gcd_data_q    <= gcd_data_d;
            clear_q       <= (state_d == StClear);
            res_valid_q   <= (state_d == StResp);
            res_data_q    <= (state_d == StResp) ? result_d : '0;
            res_timeout_q <= (state_d == StResp) ? timeout_d : 1'b0;
            busy_q        <= (state_d != StIdle);
        end
    end

    assign op_ready    = op_ready_q;
    assign gcd_start   = gcd_start_q;
    assign gcd_data    = gcd_data_q;
    // The engine is also cleared while the driver itself is in reset
    assign gcd_rst     = reset | clear_q;
    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign res_timeout = res_timeout_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_gcd_driver.sv
// Bench for gcd_driver.
// A behavioural repeated-subtraction engine sits on the engine port.
// It can be overridden to force done and result for the timeout and collision cases.
// Expected results are pushed to a queue when a job is issued and popped when the result appears.

module tb_gcd_driver;

    localparam int unsigned W  = 16;
    localparam int unsigned TO = 20;

    logic          clock;
    logic          reset;
    logic          op_valid;
    logic          op_ready;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic          gcd_start;
    logic [W-1:0]  gcd_data;
    logic          gcd_rst;
    logic          gcd_done;
    logic [W-1:0]  gcd_result;
    logic          res_valid;
    logic          res_ready;
    logic [W-1:0]  res_data;
    logic          res_timeout;
    logic          busy;

    typedef struct packed {
        logic [W-1:0] data;
        logic         timeout;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    gcd_driver #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clock       (clock),
        .reset       (reset),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .gcd_start   (gcd_start),
        .gcd_data    (gcd_data),
        .gcd_rst     (gcd_rst),
        .gcd_done    (gcd_done),
        .gcd_result  (gcd_result),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_timeout (res_timeout),
        .busy        (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural engine: load A on start, B next cycle, then subtract until equal; done is sticky
    logic [1:0]   eng_st   = 2'd0;
    logic [W-1:0] eng_a    = '0;
    logic [W-1:0] eng_b    = '0;
    logic         eng_done = 1'b0;
    logic         force_en     = 1'b0;
    logic         force_done   = 1'b0;
    logic [W-1:0] force_result = '0;
    int           start_cnt    = 0;

    always @(posedge clock) begin
        if (gcd_rst) begin
            eng_st   <= 2'd0;
            eng_a    <= '0;
            eng_b    <= '0;
            eng_done <= 1'b0;
        end else begin
            case (eng_st)
                2'd0: if (gcd_start) begin
                    eng_a  <= gcd_data;
                    eng_st <= 2'd1;
                end
                2'd1: begin
                    eng_b  <= gcd_data;
                    eng_st <= 2'd2;
                end
                2'd2: begin
                    if (eng_a == eng_b) begin
                        eng_done <= 1'b1;
                        eng_st   <= 2'd3;
                    end else if (eng_a > eng_b) begin
                        eng_a <= eng_a - eng_b;
                    end else begin
                        eng_b <= eng_b - eng_a;
                    end
                end
                default: ;
            endcase
        end
    end

    always @(posedge clock) begin
        if (gcd_start) start_cnt <= start_cnt + 1;
    end

    assign gcd_done   = force_en ? force_done : eng_done;
    assign gcd_result = force_en ? force_result : eng_a;

    function automatic exp_t mk(input logic [W-1:0] d, input logic t);
        exp_t e;
        e.data    = d;
        e.timeout = t;
        return e;
    endfunction

    // Presents one pair; returns at the negedge after the accepting edge
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        while (!op_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!op_ready) return;
        op_a     = a;
        op_b     = b;
        op_valid = 1'b1;
        @(negedge clock);
        op_valid = 1'b0;
        ok       = 1'b1;
    endtask

    task automatic wait_res(input int max, output bit ok);
        int n;
        n = 0;
        while (!res_valid && n < max) begin
            @(negedge clock);
            n++;
        end
        ok = res_valid;
    endtask

    task automatic test_reset;
        reset     = 1'b1;
        op_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        res_ready = 1'b1;
        repeat (2) @(negedge clock);
        checks++;
        if (gcd_rst !== 1'b1) begin
            errors++;
            $display("FAIL reset_gcd_rst: got %0b expected 1", gcd_rst);
        end
        checks++;
        if ({op_ready, gcd_start, res_valid, res_timeout, busy} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_flags: got %05b expected 10000",
                     {op_ready, gcd_start, res_valid, res_timeout, busy});
        end
        checks++;
        if ({gcd_data, res_data} !== '0) begin
            errors++;
            $display("FAIL reset_data: got gcd_data=%0d res_data=%0d expected 0/0", gcd_data, res_data);
        end
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if ({gcd_rst, op_ready} !== 2'b01) begin
            errors++;
            $display("FAIL reset_release: got rst/ready=%02b expected 01", {gcd_rst, op_ready});
        end
    endtask

    task automatic test_normal;
        bit   ok;
        int   s0;
        exp_t e;
        exp_q.push_back(mk(16'd13, 1'b0));
        s0 = start_cnt;
        send(16'd143, 16'd78, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL normal_accept: got not accepted expected accepted");
        end
        checks++;
        if ({gcd_start, gcd_data} !== {1'b1, 16'd143}) begin
            errors++;
            $display("FAIL normal_load_a: got start=%0b data=%0d expected 1/143", gcd_start, gcd_data);
        end
        @(negedge clock);
        checks++;
        if ({gcd_start, gcd_data} !== {1'b0, 16'd78}) begin
            errors++;
            $display("FAIL normal_load_b: got start=%0b data=%0d expected 0/78", gcd_start, gcd_data);
        end
        wait_res(40, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL normal_res_valid: got 0 expected 1 within 40 cycles");
        end
        checks++;
        if (start_cnt - s0 !== 1) begin
            errors++;
            $display("FAIL normal_start_len: got %0d start cycles expected 1", start_cnt - s0);
        end
        e = exp_q.pop_front();
        checks++;
        if ({res_data, res_timeout} !== {e.data, e.timeout}) begin
            errors++;
            $display("FAIL normal_result: got %0d/%0b expected %0d/%0b",
                     res_data, res_timeout, e.data, e.timeout);
        end
        @(negedge clock);
        checks++;
        if ({gcd_rst, res_valid} !== 2'b10) begin
            errors++;
            $display("FAIL normal_clear: got rst/valid=%02b expected 10", {gcd_rst, res_valid});
        end
        @(negedge clock);
        checks++;
        if ({gcd_rst, op_ready} !== 2'b01) begin
            errors++;
            $display("FAIL normal_idle: got rst/ready=%02b expected 01", {gcd_rst, op_ready});
        end
    endtask

    task automatic test_zero;
        logic [W-1:0] za [3];
        logic [W-1:0] zb [3];
        logic [W-1:0] ze [3];
        bit   ok;
        int   s0;
        exp_t e;
        za[0] = 16'd0;  zb[0] = 16'd25; ze[0] = 16'd25;
        za[1] = 16'd0;  zb[1] = 16'd0;  ze[1] = 16'd0;
        za[2] = 16'd40; zb[2] = 16'd0;  ze[2] = 16'd40;
        s0 = start_cnt;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(mk(ze[i], 1'b0));
            send(za[i], zb[i], ok);
            e = exp_q.pop_front();
            checks++;
            if ({ok, res_valid, res_data, res_timeout} !== {1'b1, 1'b1, e.data, 1'b0}) begin
                errors++;
                $display("FAIL zero_%0d: got ok=%0b valid=%0b data=%0d to=%0b expected 1/1/%0d/0",
                         i, ok, res_valid, res_data, res_timeout, e.data);
            end
            @(negedge clock);
            checks++;
            if (gcd_rst !== 1'b1) begin
                errors++;
                $display("FAIL zero_clear_%0d: got gcd_rst=%0b expected 1", i, gcd_rst);
            end
            @(negedge clock);
        end
        checks++;
        if (start_cnt != s0) begin
            errors++;
            $display("FAIL zero_no_start: got %0d start cycles expected 0", start_cnt - s0);
        end
    endtask

    task automatic test_backpressure;
        bit   ok;
        exp_t e;
        res_ready = 1'b0;
        exp_q.push_back(mk(16'd6, 1'b0));
        send(16'd48, 16'd18, ok);
        wait_res(40, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL bp_res_valid: got 0 expected 1 within 40 cycles");
        end
        e = exp_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clock);
            checks++;
            if ({res_valid, res_data, res_timeout} !== {1'b1, e.data, e.timeout}) begin
                errors++;
                $display("FAIL bp_hold_%0d: got valid=%0b data=%0d to=%0b expected 1/%0d/%0b",
                         i, res_valid, res_data, res_timeout, e.data, e.timeout);
            end
        end
        res_ready = 1'b1;
        @(negedge clock);
        checks++;
        if ({res_valid, gcd_rst} !== 2'b01) begin
            errors++;
            $display("FAIL bp_complete: got valid/rst=%02b expected 01", {res_valid, gcd_rst});
        end
        @(negedge clock);
    endtask

    task automatic test_timeout;
        bit   ok;
        int   cyc;
        exp_t e;
        force_en   = 1'b1;
        force_done = 1'b0;
        exp_q.push_back(mk(16'd0, 1'b1));
        send(16'd5, 16'd3, ok);
        cyc = 1;
        while (!res_valid && cyc < 60) begin
            @(negedge clock);
            if (!res_valid) cyc++;
        end
        // cyc counts LOAD_A and LOAD_B as well as the wait cycles
        checks++;
        if (cyc - 2 != int'(TO)) begin
            errors++;
            $display("FAIL timeout_wait_cycles: got %0d expected %0d", cyc - 2, TO);
        end
        e = exp_q.pop_front();
        checks++;
        if ({res_valid, res_data, res_timeout} !== {1'b1, e.data, e.timeout}) begin
            errors++;
            $display("FAIL timeout_result: got valid=%0b data=%0d to=%0b expected 1/%0d/%0b",
                     res_valid, res_data, res_timeout, e.data, e.timeout);
        end
        repeat (2) @(negedge clock);
        force_en = 1'b0;
    endtask

    task automatic test_collision;
        bit   ok;
        exp_t e;
        force_en     = 1'b1;
        force_done   = 1'b0;
        force_result = 16'd7;
        exp_q.push_back(mk(16'd7, 1'b0));
        send(16'd9, 16'd6, ok);
        // Advance from LOAD_A to the 20th wait cycle
        repeat (21) @(negedge clock);
        checks++;
        if ({busy, res_valid} !== 2'b10) begin
            errors++;
            $display("FAIL collide_pre: got busy/valid=%02b expected 10", {busy, res_valid});
        end
        force_done = 1'b1;
        @(negedge clock);
        force_done = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if ({res_valid, res_data, res_timeout} !== {1'b1, e.data, e.timeout}) begin
            errors++;
            $display("FAIL collide_result: got valid=%0b data=%0d to=%0b expected 1/%0d/%0b",
                     res_valid, res_data, res_timeout, e.data, e.timeout);
        end
        repeat (2) @(negedge clock);
        force_en = 1'b0;
    endtask

    task automatic test_reset_mid;
        bit ok;
        int seen;
        send(16'd143, 16'd78, ok);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, gcd_rst} !== 2'b11) begin
            errors++;
            $display("FAIL midreset_rst: got busy/gcd_rst=%02b expected 11", {busy, gcd_rst});
        end
        @(negedge clock);
        checks++;
        if ({op_ready, res_valid, busy, gcd_start} !== 4'b1000) begin
            errors++;
            $display("FAIL midreset_idle: got ready/valid/busy/start=%04b expected 1000",
                     {op_ready, res_valid, busy, gcd_start});
        end
        reset = 1'b0;
        seen  = 0;
        repeat (30) begin
            @(negedge clock);
            if (res_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL midreset_dropped: got %0d res_valid cycles expected 0", seen);
        end
    endtask

    task automatic test_back_to_back;
        bit   ok;
        exp_t e;
        exp_q.push_back(mk(16'd13, 1'b0));
        send(16'd143, 16'd78, ok);
        for (int i = 0; i < 3; i++) begin
            op_a     = 16'd9;
            op_b     = 16'd3;
            op_valid = 1'b1;
            if (i == 0) begin
                checks++;
                if ({op_ready, busy} !== 2'b01) begin
                    errors++;
                    $display("FAIL ignore_ready: got ready/busy=%02b expected 01", {op_ready, busy});
                end
            end
            @(negedge clock);
            op_valid = 1'b0;
            @(negedge clock);
        end
        wait_res(40, ok);
        e = exp_q.pop_front();
        checks++;
        if ({ok, res_data, res_timeout} !== {1'b1, e.data, e.timeout}) begin
            errors++;
            $display("FAIL ignore_first: got ok=%0b data=%0d to=%0b expected 1/%0d/%0b",
                     ok, res_data, res_timeout, e.data, e.timeout);
        end
        repeat (2) @(negedge clock);
        exp_q.push_back(mk(16'd7, 1'b0));
        send(16'd21, 16'd14, ok);
        wait_res(40, ok);
        e = exp_q.pop_front();
        checks++;
        if ({ok, res_data, res_timeout} !== {1'b1, e.data, e.timeout}) begin
            errors++;
            $display("FAIL ignore_second: got ok=%0b data=%0d to=%0b expected 1/%0d/%0b",
                     ok, res_data, res_timeout, e.data, e.timeout);
        end
        repeat (2) @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_normal();
        test_zero();
        test_backpressure();
        test_timeout();
        test_collision();
        test_reset_mid();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
